// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor plant model: FSM state encoding and
// the stall-counter width function used when MOTOR_PLANT_OVERTRAVEL_EN is defined.
package motor_pkg;

   typedef enum logic [1:0] {
      MOTOR_PLANT_IDLE    = 2'd0,
      MOTOR_PLANT_RISING  = 2'd1,
      MOTOR_PLANT_FALLING = 2'd2,
      MOTOR_PLANT_FAULT   = 2'd3
   } motor_state_t;

   // Bits needed to hold 0..cyc inclusive; never narrower than one bit.
   function automatic int unsigned ot_cnt_width(input int unsigned cyc);
      return (cyc < 1) ? 1 : $clog2(cyc + 1);
   endfunction

endpackage

// File: rtl/step_prescaler.sv
// Clock prescaler for the motor plant: emits one step pulse every STEP_DIV
// enabled clocks; clr discards any partial step.
module step_prescaler #(
   parameter int unsigned STEP_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic step
);

   localparam int unsigned   CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] div_cnt;

   // NOTE: sequential state is only ever updated with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
      end
   end

   assign step = en && !clr && (div_cnt == LAST);

endmodule

// File: rtl/motor_plant.sv
// Motor-plus-limit-switch plant: integrates position from motor_up/motor_dn and
// drives registered limit switches. Define MOTOR_PLANT_OVERTRAVEL_EN for the stall flag.
module motor_plant
   import motor_pkg::*;
#(
   parameter int unsigned POS_W          = 8,
   parameter int unsigned TRAVEL         = 200,
   parameter int unsigned STEP_DIV       = 4,
   parameter int unsigned START_POS      = 0,
   parameter int unsigned OVERTRAVEL_CYC = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             motor_up,
   input  logic             motor_dn,
   output logic             up_limit,
   output logic             dn_limit,
   output logic [POS_W-1:0] position,
   output logic             moving,
   output logic             fault,
   output logic             overtravel
);

   localparam logic [POS_W-1:0] TOP_POS = POS_W'(TRAVEL);
   localparam logic [POS_W-1:0] RST_POS = POS_W'(START_POS);
   localparam bit CFG_OK = (TRAVEL >= 1) && ((TRAVEL >> POS_W) == 0) && (STEP_DIV >= 1)
                           && (START_POS <= TRAVEL) && (OVERTRAVEL_CYC >= 1);

   motor_state_t     state;
   logic             fault_q;
   logic             run;
   logic             step_pulse;
   logic [POS_W-1:0] pos_up;
   logic [POS_W-1:0] pos_dn;

   // The prescaler only runs while the commanded direction is still held.
   assign run = ((state == MOTOR_PLANT_RISING)  && motor_up && !motor_dn) ||
                ((state == MOTOR_PLANT_FALLING) && motor_dn && !motor_up);
   assign pos_up = position + 1'b1;
   assign pos_dn = position - 1'b1;

   step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (run),
      .clr   (!run),
      .step  (step_pulse)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= MOTOR_PLANT_IDLE;
         position <= RST_POS;
         moving   <= 1'b0;
         fault_q  <= 1'b0;
         up_limit <= (RST_POS == TOP_POS);
         dn_limit <= (RST_POS == '0);
      end else begin
         unique case (state)
            MOTOR_PLANT_IDLE: begin
               if (motor_up && motor_dn) begin
                  state   <= MOTOR_PLANT_FAULT;
                  fault_q <= 1'b1;
               end else if (motor_up && (position < TOP_POS)) begin
                  state  <= MOTOR_PLANT_RISING;
                  moving <= 1'b1;
               end else if (motor_dn && (position != '0)) begin
                  state  <= MOTOR_PLANT_FALLING;
                  moving <= 1'b1;
               end
            end
            MOTOR_PLANT_RISING: begin
               if (motor_up && motor_dn) begin
                  state   <= MOTOR_PLANT_FAULT;
                  moving  <= 1'b0;
                  fault_q <= 1'b1;
               end else if (!motor_up) begin
                  state  <= MOTOR_PLANT_IDLE;
                  moving <= 1'b0;
               end else if (step_pulse && (position < TOP_POS)) begin
                  position <= pos_up;
                  up_limit <= (pos_up == TOP_POS);
                  dn_limit <= 1'b0;
                  if (pos_up == TOP_POS) begin
                     state  <= MOTOR_PLANT_IDLE;
                     moving <= 1'b0;
                  end
               end
            end
            MOTOR_PLANT_FALLING: begin
               if (motor_up && motor_dn) begin
                  state   <= MOTOR_PLANT_FAULT;
                  moving  <= 1'b0;
                  fault_q <= 1'b1;
               end else if (!motor_dn) begin
                  state  <= MOTOR_PLANT_IDLE;
                  moving <= 1'b0;
               end else if (step_pulse && (position != '0)) begin
                  position <= pos_dn;
                  dn_limit <= (pos_dn == '0);
                  up_limit <= 1'b0;
                  if (pos_dn == '0) begin
                     state  <= MOTOR_PLANT_IDLE;
                     moving <= 1'b0;
                  end
               end
            end
            MOTOR_PLANT_FAULT: begin
               if (!motor_up && !motor_dn) begin
                  state   <= MOTOR_PLANT_IDLE;
                  fault_q <= 1'b0;
               end
            end
         endcase
      end
   end

   // An out-of-range parameter set shows up as a permanent fault.
   assign fault = fault_q || !CFG_OK;

`ifdef MOTOR_PLANT_OVERTRAVEL_EN
   localparam int unsigned    OTW    = ot_cnt_width(OVERTRAVEL_CYC);
   localparam logic [OTW-1:0] OT_MAX = OTW'(OVERTRAVEL_CYC);

   logic           stall;
   logic [OTW-1:0] ot_cnt;
   logic [OTW-1:0] ot_nxt;

   assign stall  = (up_limit && motor_up && !motor_dn) || (dn_limit && motor_dn && !motor_up);
   assign ot_nxt = !stall ? '0 : (ot_cnt == OT_MAX) ? ot_cnt : ot_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ot_cnt     <= '0;
         overtravel <= 1'b0;
      end else begin
         ot_cnt <= ot_nxt;
         if (ot_nxt == OT_MAX) overtravel <= 1'b1;
      end
   end
`else
   assign overtravel = 1'b0;
`endif

endmodule

// File: tb/tb_motor_plant.sv
// Self-checking bench for motor_plant: directed scenarios followed by random
// command bursts, every edge compared against a travel/phase reference model.
module tb_motor_plant;

   localparam int unsigned POS_W    = 8;
   localparam int unsigned TRAVEL   = 10;
   localparam int unsigned STEP_DIV = 4;
   localparam int unsigned START_P  = 0;
   localparam int unsigned OT_CYC   = 16;
`ifdef MOTOR_PLANT_OVERTRAVEL_EN
   localparam bit OT_ON = 1'b1;
`else
   localparam bit OT_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             motor_up = 1'b0;
   logic             motor_dn = 1'b0;
   logic             up_limit, dn_limit, moving, fault, overtravel;
   logic [POS_W-1:0] position;

   int errors = 0;
   int checks = 0;
   string phase = "reset";

   // Reference model: travel position, direction of motion, edges spent in motion.
   int m_pos, m_dir, m_acc, m_ot;
   bit m_fault, m_otflag;

   motor_plant #(
      .POS_W(POS_W), .TRAVEL(TRAVEL), .STEP_DIV(STEP_DIV),
      .START_POS(START_P), .OVERTRAVEL_CYC(OT_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .motor_up(motor_up), .motor_dn(motor_dn),
      .up_limit(up_limit), .dn_limit(dn_limit), .position(position),
      .moving(moving), .fault(fault), .overtravel(overtravel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task model_edge(input bit up, input bit dn, input bit rst);
      bit stall, want;
      if (rst) begin
         m_pos = START_P; m_dir = 0; m_acc = 0; m_fault = 0; m_ot = 0; m_otflag = 0;
      end else begin
         stall = (m_pos == TRAVEL && up && !dn) || (m_pos == 0 && dn && !up);
         if (OT_ON) begin
            m_ot = stall ? ((m_ot < OT_CYC) ? m_ot + 1 : m_ot) : 0;
            if (m_ot == OT_CYC) m_otflag = 1;
         end
         if (m_fault) begin
            if (!up && !dn) m_fault = 0;
         end else if (up && dn) begin
            m_fault = 1; m_dir = 0; m_acc = 0;
         end else if (m_dir == 0) begin
            m_acc = 0;
            if (up && m_pos < TRAVEL) m_dir = 1;
            else if (dn && m_pos > 0) m_dir = -1;
         end else begin
            want = (m_dir > 0) ? up : dn;
            if (!want) begin
               m_dir = 0; m_acc = 0;
            end else begin
               m_acc++;
               if (m_acc == STEP_DIV) begin
                  m_acc = 0;
                  m_pos += m_dir;
                  if (m_pos == 0 || m_pos == TRAVEL) m_dir = 0;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      chk({phase, ".position"},   position,   m_pos);
      chk({phase, ".up_limit"},   up_limit,   (m_pos == TRAVEL));
      chk({phase, ".dn_limit"},   dn_limit,   (m_pos == 0));
      chk({phase, ".moving"},     moving,     (m_dir != 0));
      chk({phase, ".fault"},      fault,      m_fault);
      chk({phase, ".overtravel"}, overtravel, m_otflag);
   endtask

   task automatic cyc(input bit up, input bit dn, input bit rst);
      @(negedge clk);
      motor_up = up; motor_dn = dn; rst_n = !rst;
      @(posedge clk);
      model_edge(up, dn, rst);
      #1;
      compare_all();
   endtask

   initial begin
      bit up, dn, rs;

      phase = "reset";
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      chk("reset.position_const", position, START_P);
      chk("reset.dn_limit_const", dn_limit, 1);

      phase = "t1_rise";
      for (int e = 1; e <= 41; e++) begin
         cyc(1, 0, 0);
         if (e == 5) begin
            chk("t1.pos_e5", position, 1);
            chk("t1.dn_limit_e5", dn_limit, 0);
         end
         if (e == 41) begin
            chk("t1.pos_e41", position, 10);
            chk("t1.up_limit_e41", up_limit, 1);
            chk("t1.moving_e41", moving, 0);
         end
      end

      phase = "t2_fall";
      for (int e = 1; e <= 41; e++) begin
         cyc(0, 1, 0);
         if (e == 5) chk("t2.up_limit_e5", up_limit, 0);
         if (e == 41) begin
            chk("t2.pos_e41", position, 0);
            chk("t2.dn_limit_e41", dn_limit, 1);
         end
      end

      phase = "t3_reverse";
      for (int e = 1; e <= 15; e++) cyc(1, 0, 0);
      chk("t3.pos_before", position, 3);
      cyc(0, 1, 0);
      chk("t3.idle_gap_moving", moving, 0);
      cyc(0, 1, 0);
      chk("t3.falling_entry", moving, 1);
      for (int e = 1; e <= 4; e++) begin
         cyc(0, 1, 0);
         if (e == 3) chk("t3.pos_e3", position, 3);
         if (e == 4) chk("t3.pos_e4", position, 2);
      end
      cyc(0, 0, 0);

      phase = "t4_fault";
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(1, 1, 0);
      chk("t4.fault_set", fault, 1);
      for (int e = 0; e < 6; e++) cyc(1, 1, 0);
      chk("t4.pos_frozen", position, 2);
      cyc(0, 0, 0);
      chk("t4.fault_clr", fault, 0);
      chk("t4.idle", moving, 0);

      phase = "t5_reset_mid";
      for (int i = 0; i < 200 && m_pos != 7; i++) cyc(1, 0, 0);
      cyc(0, 0, 0);
      for (int i = 0; i < 200 && m_pos != 6; i++) cyc(0, 1, 0);
      cyc(0, 1, 0);
      chk("t5.still_falling", moving, 1);
      cyc(0, 1, 1);
      chk("t5.pos_reset", position, START_P);
      chk("t5.moving_reset", moving, 0);
      chk("t5.dn_limit_reset", dn_limit, 1);

      phase = "t6_overtravel";
      for (int i = 0; i < 200 && m_pos != TRAVEL; i++) cyc(1, 0, 0);
      for (int k = 1; k <= 20; k++) begin
         cyc(1, 0, 0);
         if (k == 15) chk("t6.ot_k15", overtravel, 0);
         if (k == 16) chk("t6.ot_k16", overtravel, OT_ON);
      end
      for (int k = 0; k < 4; k++) cyc(0, 0, 0);
      chk("t6.ot_sticky", overtravel, OT_ON);

      phase = "random";
      for (int b = 0; b < 80; b++) begin
         case ($urandom_range(0, 9))
            0:       begin up = 1; dn = 1; end
            1:       begin up = 0; dn = 0; end
            2, 3, 4, 5: begin up = 1; dn = 0; end
            default: begin up = 0; dn = 1; end
         endcase
         rs = ($urandom_range(0, 30) == 0);
         if (rs) cyc(0, 0, 1);
         for (int c = 0; c < $urandom_range(1, 24); c++) cyc(up, dn, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
